// File: rtl/midi_voice_tracker_pkg.sv
// Shared MIDI types and constants for the voice tracker and future MIDI_RX consumers.
package midi_voice_tracker_pkg;

  localparam int bits   = 7;
  localparam int voices = 4;

  typedef logic [bits-1:0] data_t;

  typedef struct packed {
    logic  active;
    data_t note;
    data_t velocity;
  } voice_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_VOLUME,
    EV_KEY_DOWN,
    EV_KEY_UP
  } ev_kind_t;

  // First match wins; a key down with zero velocity is treated as a key up.
  function automatic ev_kind_t classify(input logic pulse, input logic value,
                                        input logic note_zero, input logic vel_zero);
    if (!pulse)
      return EV_NONE;
    if (!value && note_zero)
      return EV_VOLUME;
    if (value && !vel_zero)
      return EV_KEY_DOWN;
    return EV_KEY_UP;
  endfunction

endpackage

// File: rtl/midi_voice_tracker_if.sv
// Decoded MIDI event bus as presented by MIDI_RX (ready level plus event fields).
interface midi_voice_tracker_if #(
  parameter int BITS = midi_voice_tracker_pkg::bits
);
  logic            evReady;
  logic            evValue;
  logic [BITS-1:0] evNote;
  logic [BITS-1:0] evVelocity;

  modport master (output evReady, output evValue, output evNote, output evVelocity);
  modport slave  (input  evReady, input  evValue, input  evNote, input  evVelocity);
endinterface

// File: rtl/midi_voice_tracker_ready_edge.sv
// Two-flop synchroniser and registered rising-edge detector for the MIDI_RX ready level.
module midi_ready_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic sync1_reg, sync2_reg, prev_reg, pulse_reg;

  // Flops reset to 1 so a level already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      pulse_reg <= 1'b0;
    end else begin
      sync1_reg <= level;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      pulse_reg <= sync2_reg & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;
endmodule

// File: rtl/midi_voice_tracker.sv
// Polyphonic voice table driven by decoded MIDI events; MIDI_VOICE_STEAL_EN makes a
// key down on a full table steal the oldest slot instead of counting it as dropped.
module midi_voice_tracker
  import midi_voice_tracker_pkg::*;
#(
  parameter int VOICES = voices,
  parameter int BITS   = bits
) (
  input  logic                          clk,
  input  logic                          rst,
  midi_voice_tracker_if.slave           ev,
  output logic [VOICES-1:0]             voiceActive,
  output logic [VOICES-1:0][BITS-1:0]   voiceNote,
  output logic [VOICES-1:0][BITS-1:0]   voiceVelocity,
  output logic [BITS-1:0]               volume,
  output logic [BITS-1:0]               lastNote,
  output logic [7:0]                    dropped
);
  localparam int AW = $clog2(VOICES);

  logic                         ev_pulse;
  ev_kind_t                     ev_kind;
  logic [VOICES-1:0]            active_reg, active_next, match;
  logic [VOICES-1:0][BITS-1:0]  note_reg, note_next, vel_reg, vel_next;
  logic [VOICES-1:0][AW-1:0]    age_reg, age_next;
  logic [BITS-1:0]              volume_reg, volume_next, last_reg, last_next;
  logic [7:0]                   dropped_reg, dropped_next;
  logic                         hit, any_free, accept, fresh;
  logic [AW-1:0]                hit_idx, free_idx, tgt, ref_age;

  midi_ready_edge u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (ev.evReady),
    .pulse (ev_pulse)
  );

  assign ev_kind = classify(ev_pulse, ev.evValue, ev.evNote == '0, ev.evVelocity == '0);

  generate
    for (genvar gi = 0; gi < VOICES; gi++) begin : g_match
      assign match[gi] = active_reg[gi] && (note_reg[gi] == ev.evNote);
    end
  endgenerate

  assign hit      = |match;
  assign any_free = ~&active_reg;

  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (match[i])
        hit_idx = AW'(i);
      if (!active_reg[i])
        free_idx = AW'(i);
    end
  end

`ifdef MIDI_VOICE_STEAL_EN
  logic [AW-1:0] oldest_idx;

  // Strict compare while scanning upward keeps ties on the lowest index.
  always_comb begin
    oldest_idx = '0;
    for (int i = 1; i < VOICES; i++)
      if (active_reg[i] && (age_reg[i] > age_reg[oldest_idx]))
        oldest_idx = AW'(i);
  end
`endif

  always_comb begin
    active_next  = active_reg;
    note_next    = note_reg;
    vel_next     = vel_reg;
    age_next     = age_reg;
    volume_next  = volume_reg;
    last_next    = last_reg;
    dropped_next = dropped_reg;
    accept       = 1'b0;
    fresh        = 1'b0;
    tgt          = '0;
    ref_age      = '0;
    case (ev_kind)
      EV_VOLUME: volume_next = ev.evVelocity;
      EV_KEY_DOWN: begin
        if (hit) begin
          accept  = 1'b1;
          tgt     = hit_idx;
          ref_age = age_reg[hit_idx];
        end else if (any_free) begin
          accept = 1'b1;
          fresh  = 1'b1;
          tgt    = free_idx;
        end else begin
`ifdef MIDI_VOICE_STEAL_EN
          accept  = 1'b1;
          tgt     = oldest_idx;
          ref_age = age_reg[oldest_idx];
`else
          if (dropped_reg != 8'hFF)
            dropped_next = dropped_reg + 8'd1;
`endif
        end
        // The target becomes youngest; everything younger than its old age moves up one.
        if (accept) begin
          for (int i = 0; i < VOICES; i++) begin
            if (AW'(i) == tgt) begin
              active_next[i] = 1'b1;
              note_next[i]   = ev.evNote;
              vel_next[i]    = ev.evVelocity;
              age_next[i]    = '0;
            end else if (active_reg[i] && (fresh || (age_reg[i] < ref_age))) begin
              age_next[i] = age_reg[i] + 1'b1;
            end
          end
          last_next = ev.evNote;
        end
      end
      EV_KEY_UP: begin
        if (hit) begin
          active_next[hit_idx] = 1'b0;
          for (int i = 0; i < VOICES; i++)
            if (active_reg[i] && (age_reg[i] > age_reg[hit_idx]))
              age_next[i] = age_reg[i] - 1'b1;
        end
        if (ev.evNote == last_reg)
          last_next = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg  <= '0;
      note_reg    <= '0;
      vel_reg     <= '0;
      age_reg     <= '0;
      volume_reg  <= '0;
      last_reg    <= '0;
      dropped_reg <= '0;
    end else begin
      active_reg  <= active_next;
      note_reg    <= note_next;
      vel_reg     <= vel_next;
      age_reg     <= age_next;
      volume_reg  <= volume_next;
      last_reg    <= last_next;
      dropped_reg <= dropped_next;
    end
  end

  assign voiceActive   = active_reg;
  assign voiceNote     = note_reg;
  assign voiceVelocity = vel_reg;
  assign volume        = volume_reg;
  assign lastNote      = last_reg;
  assign dropped       = dropped_reg;
endmodule

// File: tb/tb_midi_voice_tracker.sv
// Scoreboard bench for midi_voice_tracker: stimulus queues expected snapshots, a monitor checks them.
module tb_midi_voice_tracker;
  localparam int V = 4;
  localparam int B = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [V-1:0]        voiceActive;
  logic [V-1:0][B-1:0] voiceNote, voiceVelocity;
  logic [B-1:0]        volume, lastNote;
  logic [7:0]          dropped;

  midi_voice_tracker_if #(.BITS(B)) evif ();

  midi_voice_tracker #(.VOICES(V), .BITS(B)) dut (
    .clk           (clk),
    .rst           (rst),
    .ev            (evif),
    .voiceActive   (voiceActive),
    .voiceNote     (voiceNote),
    .voiceVelocity (voiceVelocity),
    .volume        (volume),
    .lastNote      (lastNote),
    .dropped       (dropped)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int                  due;
    logic [V-1:0]        act;
    logic [V-1:0][B-1:0] note;
    logic [V-1:0][B-1:0] vel;
    logic [B-1:0]        vol;
    logic [B-1:0]        last;
    logic [7:0]          drop;
  } exp_t;

  exp_t sb[$];

  // Reference model: slot contents plus an LRU list of active slots (oldest first).
  logic [V-1:0]        m_active;
  logic [V-1:0][B-1:0] m_note, m_vel;
  logic [B-1:0]        m_volume, m_last;
  logic [7:0]          m_dropped;
  int                  order[$];

  function automatic exp_t snap(input int due);
    exp_t e;
    e.due  = due;
    e.act  = m_active;
    e.note = m_note;
    e.vel  = m_vel;
    e.vol  = m_volume;
    e.last = m_last;
    e.drop = m_dropped;
    return e;
  endfunction

  task automatic model_reset();
    m_active = '0; m_note = '0; m_vel = '0;
    m_volume = '0; m_last = '0; m_dropped = '0;
    order.delete();
  endtask

  task automatic drop_order(input int s);
    int k;
    k = -1;
    foreach (order[j]) if (order[j] == s) k = j;
    if (k >= 0) order.delete(k);
  endtask

  task automatic model_event(input logic v, input logic [B-1:0] n, input logic [B-1:0] vel);
    int slot;
    bit take;
    slot = -1;
    take = 1'b1;
    if (!v && n == 0) begin
      m_volume = vel;
    end else if (v && vel != 0) begin
      for (int i = 0; i < V; i++) if (m_active[i] && m_note[i] == n) slot = i;
      if (slot >= 0) begin
        drop_order(slot);
      end else begin
        for (int i = V - 1; i >= 0; i--) if (!m_active[i]) slot = i;
        if (slot < 0) begin
`ifdef MIDI_VOICE_STEAL_EN
          slot = order.pop_front();
`else
          take = 1'b0;
          if (m_dropped != 8'hFF) m_dropped = m_dropped + 8'd1;
`endif
        end
      end
      if (take) begin
        order.push_back(slot);
        m_active[slot] = 1'b1;
        m_note[slot]   = n;
        m_vel[slot]    = vel;
        m_last         = n;
      end
    end else begin
      for (int i = 0; i < V; i++)
        if (m_active[i] && m_note[i] == n) begin
          m_active[i] = 1'b0;
          drop_order(i);
        end
      if (n == m_last) m_last = '0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: outputs are registered, so every cycle is a presentation; compare due snapshots.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("voiceActive",   64'(voiceActive),   64'(e.act));
        chk("voiceNote",     64'(voiceNote),     64'(e.note));
        chk("voiceVelocity", 64'(voiceVelocity), 64'(e.vel));
        chk("volume",        64'(volume),        64'(e.vol));
        chk("lastNote",      64'(lastNote),      64'(e.last));
        chk("dropped",       64'(dropped),       64'(e.drop));
      end
    end
  end

  // Old state must still hold 3 cycles after the drive edge, new state must be there at 4.
  task automatic send(input logic v, input logic [B-1:0] n, input logic [B-1:0] vel);
    @(negedge clk);
    sb.push_back(snap(cyc + 3));
    model_event(v, n, vel);
    sb.push_back(snap(cyc + 4));
    evif.evValue    = v;
    evif.evNote     = n;
    evif.evVelocity = vel;
    evif.evReady    = 1'b1;
    $display("ev cyc=%0d value=%0d note=%0d vel=%0d", cyc, v, n, vel);
    repeat (3) @(negedge clk);
    evif.evReady = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    wait_drain();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    sb.push_back(snap(cyc + 1));
    @(negedge clk);
    rst = 1'b0;
    $display("reset cyc=%0d", cyc);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got=%0d cycles want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    evif.evReady = 1'b0; evif.evValue = 1'b0;
    evif.evNote = '0;    evif.evVelocity = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Single key down: slot0 = {1,60,100}.
    send(1'b1, 7'd60, 7'd100);
    // Fill, release middle, refill the gap.
    send(1'b1, 7'd62, 7'd90);
    send(1'b1, 7'd64, 7'd80);
    send(1'b0, 7'd62, 7'd0);
    send(1'b1, 7'd65, 7'd70);
    // Volume event leaves voices alone.
    send(1'b0, 7'd0, 7'd90);
    // Unknown note release is a no-op; key down 0 velocity is a release.
    send(1'b0, 7'd99, 7'd5);
    send(1'b1, 7'd65, 7'd0);

    // Full table, then an overflow key down.
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b1, 7'(60 + i), 7'(10 + i));
    send(1'b1, 7'd70, 7'd100);
    for (int i = 0; i < 299; i++) send(1'b1, 7'(70 + (i % 3)), 7'd100);

    // Velocity-0 release and slot reuse without duplication.
    do_reset();
    send(1'b1, 7'd60, 7'd80);
    send(1'b1, 7'd60, 7'd0);
    send(1'b1, 7'd60, 7'd50);
    send(1'b1, 7'd60, 7'd70);

    // Age ranking: refresh 10 so 11 becomes oldest, then overflow.
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b1, 7'(10 + i), 7'd20);
    send(1'b1, 7'd10, 7'd30);
    send(1'b1, 7'd20, 7'd40);
    send(1'b0, 7'd12, 7'd0);
    send(1'b1, 7'd14, 7'd44);
    send(1'b1, 7'd21, 7'd45);

    // evReady held high across reset: nothing fires afterwards.
    wait_drain();
    @(negedge clk);
    evif.evValue = 1'b1; evif.evNote = 7'd5; evif.evVelocity = 7'd5;
    evif.evReady = 1'b1;
    rst = 1'b1;
    model_reset();
    sb.push_back(snap(cyc + 1));
    $display("reset with ready high cyc=%0d", cyc);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(snap(cyc + 3));
    sb.push_back(snap(cyc + 6));
    repeat (7) @(negedge clk);
    evif.evReady = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the evPulse cycle discards the event.
    send(1'b1, 7'd30, 7'd31);
    wait_drain();
    @(negedge clk);
    evif.evValue = 1'b1; evif.evNote = 7'd9; evif.evVelocity = 7'd9;
    evif.evReady = 1'b1;
    $display("ev with reset in pulse cycle cyc=%0d", cyc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    sb.push_back(snap(cyc + 1));
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(snap(cyc + 4));
    repeat (6) @(negedge clk);
    evif.evReady = 1'b0;
    repeat (3) @(negedge clk);

    wait_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/midi_voice_tracker.md
# midi_voice_tracker

Parametrised polyphonic successor to the single-note MIDI latch. Consumes decoded MIDI events from `MIDI_RX` and maintains a table of up to `VOICES` held notes with velocities, plus master volume and most-recent note, all in the `clk` domain. Feeds per-voice data to the video display and later synthesis logic. Replaces the old scheme of clocking registers directly on `midi.ready`.

## Interface
Parameters:
- `VOICES`, default 4: number of voice slots (2..16).
- `BITS`, default 7: MIDI data field width; equals `MIDI::bits`.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `evReady`  in  1  raw `midi.ready` level from `MIDI_RX`, asynchronous to `clk`.
- `evValue`  in  1  `midi.value`: 1 = key down, 0 = key up or volume.
- `evNote`  in  BITS  `midi.note`.
- `evVelocity`  in  BITS  `midi.velocity`.
- `voiceActive`  out  VOICES  per-slot held flag.
- `voiceNote`  out  [VOICES][BITS]  per-slot note number.
- `voiceVelocity`  out  [VOICES][BITS]  per-slot velocity.
- `volume`  out  BITS  last volume event value.
- `lastNote`  out  BITS  most recent key-down note; 0 once that note is released.
- `dropped`  out  8  count of key-downs lost to a full table; saturates at 255.

## Operation
- Event strobe: `evReady` passes through a 2-flop synchroniser; a rising edge of the synchronised level gives a one-cycle `evPulse`. `evNote`, `evValue`, and `evVelocity` are sampled in the `evPulse` cycle. They are stable while `evReady` is high.
- Classification on `evPulse`, first match wins:
  - `evValue==0 && evNote==0`: volume event. `volume <= evVelocity`. Voice table unchanged.
  - `evValue==1 && evVelocity!=0`: key down.
  - Otherwise: key up. This includes key down with velocity 0, per MIDI convention.
- Key down:
  - Note already active in slot k: update `voiceVelocity[k]` and make k the youngest.
  - Else, if a free slot exists: allocate the lowest-index free slot and set note, velocity, and active. The new slot is the youngest.
  - Else (table full): handling depends on `VOICE_STEAL_EN`; see Configuration.
  - In all accepted cases, `lastNote <= evNote`.
- Key up:
  - Clear `voiceActive` of the slot holding `evNote`. Note and velocity fields keep their stale values.
  - If `evNote==lastNote`, set `lastNote <= 0`.
  - Unknown note: no-op.
- Age ranking: each slot holds `age` of width `$clog2(VOICES)`, with active ages a permutation of 0..n-1.
  - New or refreshed slot: `age = 0`. Active slots younger than its old age (all active slots for a fresh allocation) increment.
  - Release: active slots older than the released slot decrement.
  - Oldest = maximum age; ties resolve to lowest index.
- At most one slot matches a given note. Duplicate allocation is impossible by construction.

## Timing
- Latency: `evReady` rise sampled at edge N → `evPulse` high in cycle N+2 → outputs updated at edge N+3.
- Minimum event spacing is 4 clk cycles, far below the MIDI byte rate. No back-pressure.
- Reset values:
  - All `voiceActive`, `voiceNote`, `voiceVelocity`, and ages: 0.
  - `volume`, `lastNote`, `dropped`: 0.
  - Synchroniser flops: 1, so an `evReady` held high through reset release produces no event.
- `rst` high in the `evPulse` cycle: reset wins and the event is discarded.
- Outputs are registered, with no combinational path from inputs.

## Configuration
- Macro `MIDI_VOICE_STEAL_EN`.
- Defined: a key down on a full table steals the oldest slot. The slot takes the new note and velocity and becomes youngest. `dropped` is unchanged.
- Undefined: the event is ignored, except that `dropped` increments (saturating at 255). Table and `lastNote` are unchanged.

## Structure
- Package `MIDI` (shared) gains `voices` (default 4), `typedef logic [bits-1:0] data_t`, and `typedef struct packed { logic active; data_t note; data_t velocity; } voice_t`.
- Sub-module `midi_ready_edge`: 2-flop synchroniser plus rising-edge detector, with reset value 1. It is reused by any future `MIDI_RX` consumer.
- Top-level display wiring moves `numbers[9]` to `volume` and the note display to `lastNote`.

## Test plan
- Reset, then key down 60/vel 100 → slot0 = {1,60,100}, `lastNote`=60, 3 cycles after the `evReady` rise.
- Key down 60, 62, 64; key up 62 → slot1 inactive; a new key down 65 lands in slot1 and `lastNote`=65.
- Volume event (value 0, note 0, vel 90) → `volume`=90, voice table and `lastNote` unchanged.
- Fill 4 slots with 60..63, then key down 70:
  - With macro: slot0 (oldest) → 70.
  - Without macro: table unchanged, `dropped`=1. After 300 such events, `dropped`=255.
- Key down 60 vel 80, then key down 60 vel 0 → slot0 inactive, `lastNote`=0. A repeated key down 60 vel 50 reuses slot0 and only one slot holds 60.
- Hold `evReady` high across an `rst` pulse → no event, all outputs 0. Assert `rst` in the `evPulse` cycle → event lost.
